// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the single-cycle core's data-memory
// interface. DEPTH x 32-bit word array with a combinational core read port,
// a synchronous core write port, a host preload/dump port that only uses
// cycles the core leaves free (CEN=1), saturating core access counters and
// a sticky protocol-error flag.
module dmem_responder #(
   parameter int AW      = 7,
   parameter int DEPTH   = 128,
   parameter int TIMEOUT = 16,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // core side
   input  logic          CEN,
   input  logic          WEN,
   input  logic          OEN,
   input  logic [AW-1:0] A,
   input  logic [31:0]   Data2Mem,
   output logic [31:0]   ReadDataMem,
   // host side
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [31:0]   host_wdata,
   output logic [31:0]   host_rdata,
   output logic          host_ack,
   output logic          host_err,
   // status
   output logic [CW-1:0] rd_cnt,
   output logic [CW-1:0] wr_cnt,
   output logic          proto_err
);

   // Wait counter only needs to reach TIMEOUT-1.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } host_state_t;

   logic [31:0]   r_mem [DEPTH];
   host_state_t   r_state;
   logic [TW-1:0] r_wait_cnt;
   logic [31:0]   r_host_rdata;
   logic          r_host_ack;
   logic          r_host_err;
   logic [CW-1:0] r_rd_cnt;
   logic [CW-1:0] r_wr_cnt;
   logic          r_proto_err;

   logic          w_core_rd;
   logic          w_core_wr;
   logic          w_host_go;
   logic          w_host_wr;
   logic          w_timeout;

   // Decode core strobes and the cycle in which the host access may proceed.
   always_comb begin
      w_core_rd = 1'b0;
      w_core_wr = 1'b0;
      w_host_go = 1'b0;
      w_host_wr = 1'b0;
      w_timeout = 1'b0;
      if (!CEN) begin
         w_core_rd = !OEN;
         w_core_wr = !WEN;
      end else begin
         w_core_rd = 1'b0;
         w_core_wr = 1'b0;
      end
      // Host only ever moves in a cycle the core has released (CEN=1), so a
      // host write can never coincide with a core write.
      if (rst_n && host_req && CEN &&
          ((r_state == ST_IDLE) || (r_state == ST_WAIT))) begin
         w_host_go = 1'b1;
         w_host_wr = host_we;
      end else begin
         w_host_go = 1'b0;
         w_host_wr = 1'b0;
      end
      w_timeout = (r_wait_cnt == TW'(TIMEOUT - 1));
   end

   // Core read data is combinational; the core consumes it in the same cycle.
   assign ReadDataMem = w_core_rd ? r_mem[A] : 32'h0000_0000;

   // Memory array write port; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (w_core_wr) begin
         r_mem[A] <= Data2Mem;
      end else if (w_host_wr) begin
         r_mem[host_addr] <= host_wdata;
      end
   end

   // Host request FSM: arbitration behind the core, timeout and ack pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_wait_cnt   <= '0;
         r_host_rdata <= 32'h0000_0000;
         r_host_ack   <= 1'b0;
         r_host_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_host_ack <= 1'b0;
               r_host_err <= 1'b0;
               if (w_host_go) begin
                  if (!host_we) begin
                     r_host_rdata <= r_mem[host_addr];
                  end
                  r_host_ack <= 1'b1;
                  r_state    <= ST_ACK;
               end else if (host_req) begin
                  r_wait_cnt <= '0;
                  r_state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_host_ack <= 1'b0;
               r_host_err <= 1'b0;
               if (!host_req) begin
                  // Requester gave up: drop silently, no ack.
                  r_state <= ST_IDLE;
               end else if (w_host_go) begin
                  if (!host_we) begin
                     r_host_rdata <= r_mem[host_addr];
                  end
                  r_host_ack <= 1'b1;
                  r_state    <= ST_ACK;
               end else if (w_timeout) begin
                  // Core never released the memory: abort without access.
                  r_host_ack <= 1'b1;
                  r_host_err <= 1'b1;
                  r_state    <= ST_ACK;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TW'(1);
               end
            end
            ST_ACK: begin
               r_host_ack <= 1'b0;
               r_host_err <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_host_ack <= 1'b0;
               r_host_err <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating core access counters and sticky WEN/OEN conflict flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_core_rd && (r_rd_cnt != {CW{1'b1}})) begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
         end
         if (w_core_wr && (r_wr_cnt != {CW{1'b1}})) begin
            r_wr_cnt <= r_wr_cnt + CW'(1);
         end
         if (w_core_rd && w_core_wr) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign host_rdata = r_host_rdata;
   assign host_ack   = r_host_ack;
   assign host_err   = r_host_err;
   assign rd_cnt     = r_rd_cnt;
   assign wr_cnt     = r_wr_cnt;
   assign proto_err  = r_proto_err;

endmodule
